flag_compare_unit: RTL and testbench

//  Multi-cycle, handshaked successor of the combinational flagger. Compares two WORDSIZE

---
 rtl/flag_compare_unit.sv | 189 ++++++++++++++++++
 tb/tb_flag_compare_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/flag_compare_unit.sv
// Multi-cycle MSB-first chunked comparator producing relation flags and a RISC-V branch decision.
// Optional build macro FLAG_CMP_EARLY_EXIT_EN finishes the scan at the first differing slice.
module flag_compare_unit #(
  parameter int WORDSIZE = 64,
  parameter int CHUNK    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDSIZE-1:0] input_a,
  input  logic [WORDSIZE-1:0] input_b,
  input  logic [2:0]          funct3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                flag_equal,
  output logic                flag_not_equal,
  output logic                flag_greater,
  output logic                flag_less,
  output logic                flag_u_greater,
  output logic                flag_u_less,
  output logic                branch_taken,
  output logic                funct_illegal
);

  localparam int NCHUNK = WORDSIZE / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WORDSIZE % CHUNK) != 0) begin : g_bad_chunk
    $error("flag_compare_unit: CHUNK must divide WORDSIZE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [WORDSIZE-1:0] a_r, b_r;
  logic [2:0]          funct3_r;
  logic                sign_a_r, sign_b_r;
  logic [IDXW-1:0]     idx_r;
  logic                decided_r, u_gt_r;

  logic [CHUNK-1:0]    slice_a_s, slice_b_s;
  logic                decided_s, u_gt_s, last_s, early_s;
  logic                eq_s, ugt_s, ult_s, gt_s, lt_s, taken_s, illegal_s;

  assign in_ready = (state_r == IDLE);

  // Operands are shifted left each SCAN cycle so the active slice is always at the top.
  assign slice_a_s = a_r[WORDSIZE-1 -: CHUNK];
  assign slice_b_s = b_r[WORDSIZE-1 -: CHUNK];
  assign last_s    = (idx_r == {IDXW{1'b0}});

  // Slice comparison folded into the running decision, and the result flags derived from it.
  always_comb begin
    decided_s = decided_r;
    u_gt_s    = u_gt_r;
    if (!decided_r && (slice_a_s != slice_b_s)) begin
      decided_s = 1'b1;
      u_gt_s    = (slice_a_s > slice_b_s);
    end else begin
      decided_s = decided_r;
      u_gt_s    = u_gt_r;
    end

`ifdef FLAG_CMP_EARLY_EXIT_EN
    early_s = decided_s;
`else
    early_s = 1'b0;
`endif

    eq_s  = !decided_s;
    ugt_s = decided_s && u_gt_s;
    ult_s = decided_s && !u_gt_s;
    if (sign_a_r != sign_b_r) begin
      gt_s = sign_b_r;
      lt_s = sign_a_r;
    end else begin
      gt_s = ugt_s;
      lt_s = ult_s;
    end

    taken_s   = 1'b0;
    illegal_s = 1'b0;
    case (funct3_r)
      3'b000:         taken_s = eq_s;
      3'b001:         taken_s = !eq_s;
      3'b100:         taken_s = lt_s;
      3'b101:         taken_s = !lt_s;
      3'b110:         taken_s = ult_s;
      3'b111:         taken_s = ugt_s || eq_s;
      3'b010, 3'b011: illegal_s = 1'b1;
      default: begin
        taken_s   = 1'b0;
        illegal_s = 1'b0;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = SCAN;
        else          state_s = IDLE;
      end
      SCAN: begin
        if (last_s || early_s) state_s = DONE;
        else                   state_s = SCAN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Operand capture, scan progress and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r            <= {WORDSIZE{1'b0}};
      b_r            <= {WORDSIZE{1'b0}};
      funct3_r       <= 3'b000;
      sign_a_r       <= 1'b0;
      sign_b_r       <= 1'b0;
      idx_r          <= {IDXW{1'b0}};
      decided_r      <= 1'b0;
      u_gt_r         <= 1'b0;
      out_valid      <= 1'b0;
      flag_equal     <= 1'b0;
      flag_not_equal <= 1'b0;
      flag_greater   <= 1'b0;
      flag_less      <= 1'b0;
      flag_u_greater <= 1'b0;
      flag_u_less    <= 1'b0;
      branch_taken   <= 1'b0;
      funct_illegal  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r       <= input_a;
            b_r       <= input_b;
            funct3_r  <= funct3;
            sign_a_r  <= input_a[WORDSIZE-1];
            sign_b_r  <= input_b[WORDSIZE-1];
            idx_r     <= IDXW'(NCHUNK - 1);
            decided_r <= 1'b0;
            u_gt_r    <= 1'b0;
          end
        end
        SCAN: begin
          a_r       <= a_r << CHUNK;
          b_r       <= b_r << CHUNK;
          idx_r     <= idx_r - IDXW'(1);
          decided_r <= decided_s;
          u_gt_r    <= u_gt_s;
          if (state_s == DONE) begin
            out_valid      <= 1'b1;
            flag_equal     <= eq_s;
            flag_not_equal <= !eq_s;
            flag_greater   <= gt_s;
            flag_less      <= lt_s;
            flag_u_greater <= ugt_s;
            flag_u_less    <= ult_s;
            branch_taken   <= taken_s;
            funct_illegal  <= illegal_s;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_compare_unit.sv
// Directed self-checking bench for flag_compare_unit with a scoreboard queue of expected results.
module tb_flag_compare_unit;

  localparam int W = 64;
  localparam int C = 16;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         reset, in_valid, out_ready;
  logic [W-1:0] input_a, input_b;
  logic [2:0]   funct3;
  logic         in_ready, out_valid;
  logic         flag_equal, flag_not_equal, flag_greater, flag_less;
  logic         flag_u_greater, flag_u_less, branch_taken, funct_illegal;
  logic [7:0]   obs_flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] flags;
    int         lat;
  } exp_t;

  exp_t sb[$];

  flag_compare_unit #(.WORDSIZE(W), .CHUNK(C)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input_a(input_a), .input_b(input_b), .funct3(funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .flag_equal(flag_equal), .flag_not_equal(flag_not_equal),
    .flag_greater(flag_greater), .flag_less(flag_less),
    .flag_u_greater(flag_u_greater), .flag_u_less(flag_u_less),
    .branch_taken(branch_taken), .funct_illegal(funct_illegal)
  );

  always #5 clk = ~clk;

  assign obs_flags = {flag_equal, flag_not_equal, flag_greater, flag_less,
                      flag_u_greater, flag_u_less, branch_taken, funct_illegal};

  function automatic logic [7:0] model_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] f);
    logic eq, gt, lt, ugt, ult, tk, ill;
    eq  = (a == b);
    ugt = (a > b);
    ult = (a < b);
    gt  = ($signed(a) > $signed(b));
    lt  = ($signed(a) < $signed(b));
    tk  = 1'b0;
    ill = 1'b0;
    case (f)
      3'b000:  tk = eq;
      3'b001:  tk = !eq;
      3'b100:  tk = lt;
      3'b101:  tk = !lt;
      3'b110:  tk = ult;
      3'b111:  tk = !ult;
      default: ill = 1'b1;
    endcase
    return {eq, !eq, gt, lt, ugt, ult, tk, ill};
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef FLAG_CMP_EARLY_EXIT_EN
    for (int k = N - 1; k >= 0; k--) begin
      if (a[k*C +: C] != b[k*C +: C]) return N - k;
    end
`endif
    return N;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] f, input int hold);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    input_a  = a;
    input_b  = b;
    funct3   = f;
    in_valid = 1'b1;
    e.flags  = model_flags(a, b, f);
    e.lat    = model_lat(a, b);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    check("latency", 32'(cyc), 32'(e.lat));
    check("flags", 32'(obs_flags), 32'(e.flags));
    // Stall the consumer; an in_valid pulse arrives mid-stall and must be ignored.
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        in_valid = 1'b1;
        input_a  = ~a;
        funct3   = 3'b001;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_flags", 32'(obs_flags), 32'(e.flags));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_flags_kept", 32'(obs_flags), 32'(e.flags));
    if (hold > 0) begin
      repeat (N + 2) @(posedge clk);
      #1;
      check("no_phantom_result", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    input_a   = '0;
    input_b   = '0;
    funct3    = 3'b000;
    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_flags", 32'(obs_flags), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(64'd5, 64'd2, 3'b100, 0);
    run_op(64'd5, 64'd5, 3'b000, 0);
    run_op(64'd2, 64'h8000_0000_0000_0002, 3'b110, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b101, 5);
    run_op(64'd1, 64'd1, 3'b010, 0);
    run_op(64'd1, 64'd1, 3'b011, 0);
    run_op(64'h0000_1234_0000_0000, 64'h0000_1233_FFFF_FFFF, 3'b001, 0);
    run_op(64'h0000_0000_0001_0000, 64'h0000_0000_0002_0000, 3'b111, 0);
    run_op(64'd7, 64'd7, 3'b111, 0);
    run_op(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b100, 0);
    run_op(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b111, 0);

    // Abort an operation with reset during its second SCAN cycle.
    input_a  = 64'd9;
    input_b  = 64'd3;
    funct3   = 3'b000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_flags_cleared", 32'(obs_flags), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", 32'(out_valid), 32'd0);
    end
    run_op(64'd3, 64'd9, 3'b110, 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
